// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone definitions for the peripheral slave models.
// Contents: CTI/BTE encodings, slave FSM state enum, burst helpers
//   wb_is_last  - 1 when a completed beat with this cti ends the transfer
//   wb_next_idx - next word index of an incrementing burst for a given bte
package peripheral_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // Reserved cti codes are treated like classic/end-of-burst.
  function automatic logic wb_is_last(input logic [2:0] cti);
    return !((cti == CTI_CONST) || (cti == CTI_INC));
  endfunction

  // Only the wrap-width low bits advance; everything above is held.
  function automatic logic [31:0] wb_next_idx(input logic [31:0] idx,
                                              input logic [1:0]  bte);
    logic [31:0] inc;
    logic [31:0] res;
    inc = idx + 32'd1;
    case (bte)
      BTE_WRAP4:  res = {idx[31:2], inc[1:0]};
      BTE_WRAP8:  res = {idx[31:3], inc[2:0]};
      BTE_WRAP16: res = {idx[31:4], inc[3:0]};
      default:    res = inc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/peripheral_adr_gen_wb.sv
// Word-index generator for the memory slave.
// Ports:
//   wb_clk, wb_rst_n     clock, synchronous active-low reset
//   wb_adr_i             byte address from the bus
//   load                 capture start_idx as the current index
//   advance              step the current index per cti/bte
//   wb_cti_i, wb_bte_i   burst control of the beat being completed
//   start_idx/start_err  index decoded from wb_adr_i and its error-window hit
//   cur_idx/cur_err      latched index of the beat in progress
//   step_idx/step_err    index of the following beat if this one completes
module peripheral_adr_gen_wb
  import peripheral_wb_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          AW       = 32,
  parameter int          DEPTH    = 256,
  parameter int unsigned ERR_BASE = 0,
  parameter int unsigned ERR_SIZE = 0,
  parameter int          IW       = $clog2(DEPTH)
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [AW-1:0] wb_adr_i,
  input  logic          load,
  input  logic          advance,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [IW-1:0] start_idx,
  output logic          start_err,
  output logic [IW-1:0] cur_idx,
  output logic          cur_err,
  output logic [IW-1:0] step_idx,
  output logic          step_err
);

  localparam int BW = $clog2(DW / 8);

  // Only the word-index slice is decoded; the rest aliases.
  logic adr_unused;
  assign adr_unused = ^wb_adr_i;

  function automatic logic in_window(input logic [IW-1:0] idx);
    logic [31:0] w;
    w = 32'(idx);
    return (ERR_SIZE != 0) && (w >= ERR_BASE) && (w < ERR_BASE + ERR_SIZE);
  endfunction

  assign start_idx = wb_adr_i[BW +: IW];
  assign start_err = in_window(start_idx);
  assign cur_err   = in_window(cur_idx);

  // Constant-address bursts and terminating beats keep the index.
  always_comb begin
    step_idx = cur_idx;
    if (wb_cti_i == CTI_INC) begin
      step_idx = IW'(wb_next_idx(32'(cur_idx), wb_bte_i));
    end
  end

  assign step_err = in_window(step_idx);

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      cur_idx <= '0;
    end else if (load) begin
      cur_idx <= start_idx;
    end else if (advance) begin
      cur_idx <= step_idx;
    end
  end

endmodule

// File: rtl/peripheral_slave_mem_wb.sv
// Wishbone B4 slave backed by a word memory, with programmable wait states,
// an error window and registered incrementing/wrapping bursts.
// Ports:
//   wb_clk, wb_rst_n   clock, synchronous active-low reset
//   wb_adr_i           byte address (word index aliases modulo DEPTH)
//   wb_dat_i, wb_sel_i write data and byte lane enables
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i  bus control
//   wb_dat_o           registered read data (0 unless ack)
//   wb_ack_o, wb_err_o registered terminations; wb_rty_o tied low
//
// state   | meaning
// IDLE    | no transfer; request captured on cyc&stb
// WAIT    | wait-state countdown before the first response
// RESP    | ack or err presented; beat completes on stb
module peripheral_slave_mem_wb
  import peripheral_wb_pkg::*;
#(
  parameter int          DW          = 32,
  parameter int          AW          = 32,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter int unsigned ERR_BASE    = 0,
  parameter int unsigned ERR_SIZE    = 0
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int IW    = $clog2(DEPTH);
  localparam int SW    = DW / 8;
  localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  logic [DW-1:0] mem [DEPTH];

  wb_state_e     state_q, state_nxt;
  logic [3:0]    cnt_q, cnt_nxt;
  logic          we_q, we_nxt;
  logic          ack_nxt, err_nxt;
  logic [DW-1:0] dat_nxt;
  logic          load, advance, mem_we;
  logic [DW-1:0] wmerge;

  logic [IW-1:0] start_idx, cur_idx, step_idx;
  logic          start_err, cur_err, step_err;

  assign wb_rty_o = 1'b0;

  peripheral_adr_gen_wb #(
    .DW       (DW),
    .AW       (AW),
    .DEPTH    (DEPTH),
    .ERR_BASE (ERR_BASE),
    .ERR_SIZE (ERR_SIZE),
    .IW       (IW)
  ) u_adr_gen (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .wb_adr_i  (wb_adr_i),
    .load      (load),
    .advance   (advance),
    .wb_cti_i  (wb_cti_i),
    .wb_bte_i  (wb_bte_i),
    .start_idx (start_idx),
    .start_err (start_err),
    .cur_idx   (cur_idx),
    .cur_err   (cur_err),
    .step_idx  (step_idx),
    .step_err  (step_err)
  );

  // Current word with the write lanes applied; also forwarded as read data
  // when a constant-address write burst re-reads the same word.
  always_comb begin
    wmerge = mem[cur_idx];
    for (int n = 0; n < SW; n++) begin
      if (wb_sel_i[n]) begin
        wmerge[8*n +: 8] = wb_dat_i[8*n +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    we_nxt    = we_q;
    ack_nxt   = wb_ack_o;
    err_nxt   = wb_err_o;
    dat_nxt   = wb_dat_o;
    load      = 1'b0;
    advance   = 1'b0;
    mem_we    = 1'b0;

    if (!wb_cyc_i) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      ack_nxt   = 1'b0;
      err_nxt   = 1'b0;
      dat_nxt   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_nxt = 1'b0;
          err_nxt = 1'b0;
          dat_nxt = '0;
          if (wb_stb_i) begin
            load   = 1'b1;
            we_nxt = wb_we_i;
            if (WAIT_STATES > 0) begin
              state_nxt = ST_WAIT;
              cnt_nxt   = 4'(WS_M1);
            end else begin
              state_nxt = ST_RESP;
              ack_nxt   = !start_err;
              err_nxt   = start_err;
              dat_nxt   = start_err ? '0 : mem[start_idx];
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_nxt = ST_RESP;
            ack_nxt   = !cur_err;
            err_nxt   = cur_err;
            dat_nxt   = cur_err ? '0 : mem[cur_idx];
          end else begin
            cnt_nxt = cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (wb_stb_i) begin
            mem_we = we_q && !wb_err_o;
            if (wb_err_o || wb_is_last(wb_cti_i)) begin
              state_nxt = ST_IDLE;
              ack_nxt   = 1'b0;
              err_nxt   = 1'b0;
              dat_nxt   = '0;
            end else begin
              // Burst continues: next beat's response is registered now.
              advance = 1'b1;
              ack_nxt = !step_err;
              err_nxt = step_err;
              if (step_err) begin
                dat_nxt = '0;
              end else if (we_q && (step_idx == cur_idx)) begin
                dat_nxt = wmerge;
              end else begin
                dat_nxt = mem[step_idx];
              end
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      we_q     <= we_nxt;
      wb_ack_o <= ack_nxt;
      wb_err_o <= err_nxt;
      wb_dat_o <= dat_nxt;
    end
  end

  // Contents survive reset; a write completing on a reset edge is dropped.
  always_ff @(posedge wb_clk) begin
    if (wb_rst_n && mem_we) begin
      mem[cur_idx] <= wmerge;
    end
  end

endmodule

// File: tb/tb_peripheral_slave_mem_wb.sv
// Bench for peripheral_slave_mem_wb: u0 has no wait states and an error
// window at words 0x20..0x23, u1 has three wait states.
module tb_peripheral_slave_mem_wb;
  import peripheral_wb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr   [2];
  logic [31:0] dat_i [2];
  logic [3:0]  sel   [2];
  logic        we    [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic [2:0]  cti   [2];
  logic [1:0]  bte   [2];
  logic [31:0] dat_o [2];
  logic        ack   [2];
  logic        err   [2];
  logic        rty   [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  peripheral_slave_mem_wb #(
    .DW(32), .AW(32), .DEPTH(256), .WAIT_STATES(0),
    .ERR_BASE(32'h20), .ERR_SIZE(4)
  ) u0 (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]), .wb_sel_i(sel[0]),
    .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_cti_i(cti[0]), .wb_bte_i(bte[0]),
    .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0])
  );

  peripheral_slave_mem_wb #(
    .DW(32), .AW(32), .DEPTH(256), .WAIT_STATES(3),
    .ERR_BASE(0), .ERR_SIZE(0)
  ) u1 (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]), .wb_sel_i(sel[1]),
    .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_cti_i(cti[1]), .wb_bte_i(bte[1]),
    .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push(input int d, input logic e, input logic c, input logic [31:0] v);
    exp_t x;
    x.err = e;
    x.chk = c;
    x.dat = v;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Monitor: every cycle with ack or err is one completed beat of ours.
  task automatic mon_one(input int d, input logic a, input logic e, input logic [31:0] v);
    exp_t x;
    int   sz;
    if (a | e) begin
      sz = (d == 0) ? q0.size() : q1.size();
      checks++;
      if (sz == 0) begin
        errors++;
        $display("FAIL unexpected_resp dut%0d actual ack=%b err=%b required no response", d, a, e);
      end else begin
        if (d == 0) x = q0.pop_front();
        else        x = q1.pop_front();
        if ((a !== !x.err) || (e !== x.err) || (x.chk && (v !== x.dat))) begin
          errors++;
          $display("FAIL resp dut%0d actual ack=%b err=%b dat=%h required err=%b dat=%h",
                   d, a, e, v, x.err, x.dat);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, ack[0], err[0], dat_o[0]);
    mon_one(1, ack[1], err[1], dat_o[1]);
  end

  task automatic idle_bus(input int d);
    cyc[d]   = 1'b0;
    stb[d]   = 1'b0;
    we[d]    = 1'b0;
    cti[d]   = CTI_CLASSIC;
    bte[d]   = BTE_LINEAR;
    sel[d]   = 4'h0;
    adr[d]   = '0;
    dat_i[d] = '0;
  endtask

  // Cycles from the request edge until ack/err is seen; 0 on timeout.
  task automatic wait_resp(input int d, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack[d] | err[d]) begin
        n = i;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic classic(input int d, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] s,
                         input int exp_lat, input string nm);
    int lat;
    adr[d] = a; we[d] = w; dat_i[d] = wd; sel[d] = s;
    cti[d] = CTI_CLASSIC; bte[d] = BTE_LINEAR;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk);
    wait_resp(d, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1 idle_bus(d);
    @(negedge clk);
    chk({nm, "_gap"}, 32'({ack[d], err[d]}), 32'd0);
  endtask

  task automatic burst(input int d, input logic [31:0] a, input logic [1:0] b,
                       input int nb, input string nm, output int seen);
    int n;
    adr[d] = a; we[d] = 1'b0; dat_i[d] = '0; sel[d] = 4'hF; bte[d] = b;
    cti[d] = (nb == 1) ? CTI_EOB : CTI_INC;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk);
    wait_resp(d, n);
    seen = 0;
    if (n != 0) begin
      for (int i = 1; i <= nb; i++) begin
        seen = i;
        if (err[d]) begin
          @(posedge clk);
          break;
        end
        cti[d] = (i == nb) ? CTI_EOB : CTI_INC;
        @(posedge clk);
        if (i == nb) break;
        @(negedge clk);
        if (!(ack[d] | err[d])) break;
      end
    end
    #1 idle_bus(d);
    @(negedge clk);
    chk({nm, "_end"}, 32'({ack[d], err[d]}), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    int quiet;
    rst_n = 1'b0;
    idle_bus(0);
    idle_bus(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ctl", 32'({ack[d], err[d], rty[d]}), 32'd0);
      chk("rst_dat", dat_o[d], 32'd0);
    end
    rst_n = 1'b1;

    // Classic write/read and byte lanes on word 4 (byte 0x10)
    push(0, 1'b0, 1'b0, 32'h0);
    classic(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1, "wr_full");
    push(0, 1'b0, 1'b1, 32'hDEADBEEF);
    classic(0, 32'h10, 1'b0, 32'h0, 4'h0, 1, "rd_full");
    push(0, 1'b0, 1'b0, 32'h0);
    classic(0, 32'h10, 1'b1, 32'h11223344, 4'b0101, 1, "wr_lanes");
    push(0, 1'b0, 1'b1, 32'hDE22BE44);
    classic(0, 32'h10, 1'b0, 32'h0, 4'h0, 1, "rd_lanes");
    // Upper address bits alias: word 0x104 is word 4
    push(0, 1'b0, 1'b1, 32'hDE22BE44);
    classic(0, 32'h410, 1'b0, 32'h0, 4'h0, 1, "rd_alias");

    // Fill words 5, 6, 7, 0x1E, 0x1F
    push(0, 1'b0, 1'b0, 32'h0);
    classic(0, 32'h14, 1'b1, 32'h05050505, 4'hF, 1, "fill5");
    push(0, 1'b0, 1'b0, 32'h0);
    classic(0, 32'h18, 1'b1, 32'h06060606, 4'hF, 1, "fill6");
    push(0, 1'b0, 1'b0, 32'h0);
    classic(0, 32'h1C, 1'b1, 32'h07070707, 4'hF, 1, "fill7");
    push(0, 1'b0, 1'b0, 32'h0);
    classic(0, 32'h78, 1'b1, 32'h1E1E1E1E, 4'hF, 1, "fill1e");
    push(0, 1'b0, 1'b0, 32'h0);
    classic(0, 32'h7C, 1'b1, 32'h1F1F1F1F, 4'hF, 1, "fill1f");

    // Wrap-4 read burst from word 6: 6,7,4,5
    push(0, 1'b0, 1'b1, 32'h06060606);
    push(0, 1'b0, 1'b1, 32'h07070707);
    push(0, 1'b0, 1'b1, 32'hDE22BE44);
    push(0, 1'b0, 1'b1, 32'h05050505);
    burst(0, 32'h18, BTE_WRAP4, 4, "wrap4", seen);
    chk("wrap4_beats", 32'(seen), 32'd4);

    // Error window 0x20..0x23, including the aliased word 0x121
    push(0, 1'b1, 1'b1, 32'h0);
    classic(0, 32'h84, 1'b1, 32'hCAFEF00D, 4'hF, 1, "err_wr");
    push(0, 1'b1, 1'b1, 32'h0);
    classic(0, 32'h84, 1'b0, 32'h0, 4'h0, 1, "err_rd");
    push(0, 1'b1, 1'b1, 32'h0);
    classic(0, 32'h484, 1'b0, 32'h0, 4'h0, 1, "err_alias");
    // Word 0x24 is just past the window
    push(0, 1'b0, 1'b0, 32'h0);
    classic(0, 32'h90, 1'b1, 32'h24242424, 4'hF, 1, "edge_wr");
    push(0, 1'b0, 1'b1, 32'h24242424);
    classic(0, 32'h90, 1'b0, 32'h0, 4'h0, 1, "edge_rd");

    // Linear 8-beat burst from 0x1E runs into the window on beat 3
    push(0, 1'b0, 1'b1, 32'h1E1E1E1E);
    push(0, 1'b0, 1'b1, 32'h1F1F1F1F);
    push(0, 1'b1, 1'b1, 32'h0);
    burst(0, 32'h78, BTE_LINEAR, 8, "eburst", seen);
    chk("eburst_beats", 32'(seen), 32'd3);

    // Reset in the middle of a linear burst from word 4
    push(0, 1'b0, 1'b1, 32'hDE22BE44);
    push(0, 1'b0, 1'b1, 32'h05050505);
    adr[0] = 32'h10; we[0] = 1'b0; sel[0] = 4'hF;
    bte[0] = BTE_LINEAR; cti[0] = CTI_INC; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk);
    wait_resp(0, n);
    chk("rstb_first_lat", 32'(n), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rstb_second_ack", 32'(ack[0]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 idle_bus(0);
    @(negedge clk);
    chk("rstb_ctl", 32'({ack[0], err[0], rty[0]}), 32'd0);
    chk("rstb_dat", dat_o[0], 32'd0);
    rst_n = 1'b1;
    push(0, 1'b0, 1'b1, 32'hDE22BE44);
    classic(0, 32'h10, 1'b0, 32'h0, 4'h0, 1, "rd_after_rst");

    // Three wait states on u1
    push(1, 1'b0, 1'b0, 32'h0);
    classic(1, 32'h24, 1'b1, 32'h00001111, 4'hF, 4, "ws_wr");
    push(1, 1'b0, 1'b1, 32'h00001111);
    classic(1, 32'h24, 1'b0, 32'h0, 4'h0, 4, "ws_rd");

    // Abort a write by dropping cyc during WAIT
    adr[1] = 32'h24; we[1] = 1'b1; dat_i[1] = 32'hFFFFFFFF; sel[1] = 4'hF;
    cti[1] = CTI_CLASSIC; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 idle_bus(1);
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1] || err[1] || (dat_o[1] != 32'h0)) quiet++;
    end
    chk("abort_quiet", 32'(quiet), 32'd0);
    push(1, 1'b0, 1'b1, 32'h00001111);
    classic(1, 32'h24, 1'b0, 32'h0, 4'h0, 4, "abort_rd");

    repeat (2) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
